// File: rtl/axi4_pkg.sv
// ----------------------------------------------------------------------------
// axi4_pkg
// Shared AXI4 encodings for the burst master: burst types, response codes,
// the burst-engine FSM state type and a helper that picks the more severe of
// two AXI response codes.
// ----------------------------------------------------------------------------
package axi4_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AW,
        ST_W,
        ST_B,
        ST_AR,
        ST_R,
        ST_DONE
    } state_e;

    // Severity order OKAY < EXOKAY < SLVERR < DECERR matches the numeric
    // encoding, so the worse response is simply the larger code.
    function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/axi4_burst_master.sv
// ----------------------------------------------------------------------------
// axi4_burst_master
// Turns one local command (write/read, start address, beats-1, ID) into one
// AXI4 INCR burst and streams beats between the local wr_*/rd_* ports and the
// AXI W/R channels. One burst is outstanding at a time; each command produces
// a single-cycle completion record on done_*.
//
// Ports
//   m00_axi_aclk / m00_axi_areset : clock, synchronous active-high reset
//   cmd_*      : command handshake and payload (cmd_len is beats-1)
//   wr_*       : write beat stream into the block (passed through to W)
//   rd_*       : read beat stream out of the block (passed through from R)
//   done_*     : one-cycle completion pulse with type, ID and AXI response
//   m00_axi_*  : AXI4 AW, W, B, AR, R channels
// ----------------------------------------------------------------------------
module axi4_burst_master
    import axi4_pkg::*;
#(
    parameter int ADDR_W  = 6,
    parameter int DATA_W  = 32,
    parameter int ID_W    = 2,
    parameter int MAX_LEN = 16
) (
    input  logic                  m00_axi_aclk,
    input  logic                  m00_axi_areset,
    // Command
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [7:0]            cmd_len,
    input  logic [ID_W-1:0]       cmd_id,
    // Local write stream
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [DATA_W/8-1:0]   wr_strb,
    // Local read stream
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  rd_last,
    // Completion
    output logic                  done_valid,
    output logic                  done_write,
    output logic [ID_W-1:0]       done_id,
    output logic [1:0]            done_resp,
    // AXI write address
    output logic [ADDR_W-1:0]     m00_axi_awaddr,
    output logic [7:0]            m00_axi_awlen,
    output logic [2:0]            m00_axi_awsize,
    output logic [1:0]            m00_axi_awburst,
    output logic [ID_W-1:0]       m00_axi_awid,
    output logic                  m00_axi_awvalid,
    input  logic                  m00_axi_awready,
    // AXI write data
    output logic [DATA_W-1:0]     m00_axi_wdata,
    output logic [DATA_W/8-1:0]   m00_axi_wstrb,
    output logic                  m00_axi_wlast,
    output logic                  m00_axi_wvalid,
    input  logic                  m00_axi_wready,
    // AXI write response
    input  logic [1:0]            m00_axi_bresp,
    input  logic [ID_W-1:0]       m00_axi_bid,
    input  logic                  m00_axi_bvalid,
    output logic                  m00_axi_bready,
    // AXI read address
    output logic [ADDR_W-1:0]     m00_axi_araddr,
    output logic [7:0]            m00_axi_arlen,
    output logic [2:0]            m00_axi_arsize,
    output logic [1:0]            m00_axi_arburst,
    output logic [ID_W-1:0]       m00_axi_arid,
    output logic                  m00_axi_arvalid,
    input  logic                  m00_axi_arready,
    // AXI read data
    input  logic [DATA_W-1:0]     m00_axi_rdata,
    input  logic [1:0]            m00_axi_rresp,
    input  logic                  m00_axi_rlast,
    input  logic                  m00_axi_rvalid,
    output logic                  m00_axi_rready
);

    localparam logic [2:0] AXSIZE    = 3'($clog2(DATA_W / 8));
    localparam logic [8:0] MAX_LEN_C = 9'(MAX_LEN);

    state_e            state_q, state_d;
    logic [8:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        len_q, len_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic              write_q, write_d;
    logic [1:0]        resp_q, resp_d;
    logic              last_beat;

    // Nine-bit counter against zero-extended len so len=255 never wraps.
    assign last_beat = (cnt_q == {1'b0, len_q});

    always_ff @(posedge m00_axi_aclk) begin
        if (m00_axi_areset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            id_q    <= '0;
            write_q <= 1'b0;
            resp_q  <= RESP_OKAY;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            id_q    <= id_d;
            write_q <= write_d;
            resp_q  <= resp_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        addr_d          = addr_q;
        len_d           = len_q;
        id_d            = id_q;
        write_d         = write_q;
        resp_d          = resp_q;
        cmd_ready       = 1'b0;
        m00_axi_awvalid = 1'b0;
        m00_axi_wvalid  = 1'b0;
        wr_ready        = 1'b0;
        m00_axi_bready  = 1'b0;
        m00_axi_arvalid = 1'b0;
        m00_axi_rready  = 1'b0;
        rd_valid        = 1'b0;
        done_valid      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // Masked during reset so no command is taken while held.
                cmd_ready = !m00_axi_areset;
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    len_d   = cmd_len;
                    id_d    = cmd_id;
                    write_d = cmd_write;
                    cnt_d   = '0;
                    if ({1'b0, cmd_len} >= MAX_LEN_C) begin
                        // Oversized burst: complete with SLVERR, no bus traffic.
                        resp_d  = RESP_SLVERR;
                        state_d = ST_DONE;
                    end else begin
                        resp_d  = RESP_OKAY;
                        state_d = cmd_write ? ST_AW : ST_AR;
                    end
                end
            end
            ST_AW: begin
                m00_axi_awvalid = 1'b1;
                if (m00_axi_awready) state_d = ST_W;
            end
            ST_W: begin
                m00_axi_wvalid = wr_valid;
                wr_ready       = m00_axi_wready;
                if (wr_valid && m00_axi_wready) begin
                    if (last_beat) begin
                        cnt_d   = '0;
                        state_d = ST_B;
                    end else begin
                        cnt_d = cnt_q + 9'd1;
                    end
                end
            end
            ST_B: begin
                m00_axi_bready = 1'b1;
                if (m00_axi_bvalid) begin
                    resp_d  = (m00_axi_bid != id_q) ? RESP_SLVERR : m00_axi_bresp;
                    state_d = ST_DONE;
                end
            end
            ST_AR: begin
                m00_axi_arvalid = 1'b1;
                if (m00_axi_arready) state_d = ST_R;
            end
            ST_R: begin
                m00_axi_rready = rd_ready;
                rd_valid       = m00_axi_rvalid;
                if (m00_axi_rvalid && rd_ready) begin
                    resp_d = resp_max(resp_q, m00_axi_rresp);
                    // rlast must appear exactly on the final counted beat.
                    if (m00_axi_rlast != last_beat) resp_d = resp_max(resp_d, RESP_SLVERR);
                    if (last_beat) begin
                        cnt_d   = '0;
                        state_d = ST_DONE;
                    end else begin
                        cnt_d = cnt_q + 9'd1;
                    end
                end
            end
            ST_DONE: begin
                done_valid = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Payloads are held from the command registers; fixed fields and
    // pass-through data are only driven while their channel is active.
    assign m00_axi_awaddr  = addr_q;
    assign m00_axi_awlen   = len_q;
    assign m00_axi_awid    = id_q;
    assign m00_axi_awsize  = (state_q == ST_AW) ? AXSIZE : 3'b000;
    assign m00_axi_awburst = (state_q == ST_AW) ? BURST_INCR : 2'b00;
    assign m00_axi_araddr  = addr_q;
    assign m00_axi_arlen   = len_q;
    assign m00_axi_arid    = id_q;
    assign m00_axi_arsize  = (state_q == ST_AR) ? AXSIZE : 3'b000;
    assign m00_axi_arburst = (state_q == ST_AR) ? BURST_INCR : 2'b00;

    assign m00_axi_wdata   = (state_q == ST_W) ? wr_data : '0;
    assign m00_axi_wstrb   = (state_q == ST_W) ? wr_strb : '0;
    assign m00_axi_wlast   = (state_q == ST_W) && last_beat;

    assign rd_data         = (state_q == ST_R) ? m00_axi_rdata : '0;
    assign rd_last         = (state_q == ST_R) && last_beat;

    assign done_write      = (state_q == ST_DONE) && write_q;
    assign done_id         = (state_q == ST_DONE) ? id_q : '0;
    assign done_resp       = (state_q == ST_DONE) ? resp_q : 2'b00;

endmodule

// File: tb/tb_axi4_burst_master.sv
module tb_axi4_burst_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [5:0]  cmd_addr;
    logic [7:0]  cmd_len;
    logic [1:0]  cmd_id;
    logic        wr_valid, wr_ready;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic        rd_valid, rd_ready, rd_last;
    logic [31:0] rd_data;
    logic        done_valid, done_write;
    logic [1:0]  done_id, done_resp;
    logic [5:0]  awaddr, araddr;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, awid, arid;
    logic        awvalid, awready, arvalid, arready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic        wlast, wvalid, wready;
    logic [1:0]  bresp, bid, rresp;
    logic        bvalid, bready, rlast, rvalid, rready;

    axi4_burst_master #(.ADDR_W(6), .DATA_W(32), .ID_W(2), .MAX_LEN(16)) dut (
        .m00_axi_aclk(clk), .m00_axi_areset(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_id(cmd_id),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_strb(wr_strb),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .done_valid(done_valid), .done_write(done_write), .done_id(done_id), .done_resp(done_resp),
        .m00_axi_awaddr(awaddr), .m00_axi_awlen(awlen), .m00_axi_awsize(awsize),
        .m00_axi_awburst(awburst), .m00_axi_awid(awid), .m00_axi_awvalid(awvalid),
        .m00_axi_awready(awready),
        .m00_axi_wdata(wdata), .m00_axi_wstrb(wstrb), .m00_axi_wlast(wlast),
        .m00_axi_wvalid(wvalid), .m00_axi_wready(wready),
        .m00_axi_bresp(bresp), .m00_axi_bid(bid), .m00_axi_bvalid(bvalid), .m00_axi_bready(bready),
        .m00_axi_araddr(araddr), .m00_axi_arlen(arlen), .m00_axi_arsize(arsize),
        .m00_axi_arburst(arburst), .m00_axi_arid(arid), .m00_axi_arvalid(arvalid),
        .m00_axi_arready(arready),
        .m00_axi_rdata(rdata), .m00_axi_rresp(rresp), .m00_axi_rlast(rlast),
        .m00_axi_rvalid(rvalid), .m00_axi_rready(rready)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Per-beat stimulus tables for the burst in flight.
    logic [31:0] beat_data [256];
    logic [3:0]  beat_strb [256];
    logic [1:0]  beat_resp [256];
    bit          beat_last [256];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference for read completion: worst rresp over the burst, raised to at
    // least SLVERR if rlast was ever misplaced relative to the final beat.
    function automatic logic [1:0] exp_read_resp(input int len);
        int  worst = 0;
        bit  err   = 0;
        for (int b = 0; b <= len; b++) begin
            if (int'(beat_resp[b]) > worst) worst = int'(beat_resp[b]);
            if (beat_last[b] != (b == len)) err = 1;
        end
        if (err && worst < 2) worst = 2;
        return 2'(worst);
    endfunction

    task automatic fill_beats(input int len, input bit resp_rand);
        for (int b = 0; b <= len; b++) begin
            beat_data[b] = $urandom;
            beat_strb[b] = 4'($urandom);
            beat_resp[b] = resp_rand ? 2'($urandom) : 2'b00;
            beat_last[b] = (b == len);
        end
    endtask

    task automatic idle_inputs();
        cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0; cmd_id = 0;
        wr_valid = 0; wr_data = 0; wr_strb = 0; rd_ready = 0;
        awready = 0; wready = 0; bresp = 0; bid = 0; bvalid = 0;
        arready = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;
    endtask

    task automatic issue_cmd(input logic w, input logic [5:0] a, input logic [7:0] l, input logic [1:0] id);
        cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_len = l; cmd_id = id;
        #1;
        chk("cmd_ready_idle", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 0;
    endtask

    task automatic check_done(input logic w, input logic [1:0] id, input logic [1:0] resp);
        #1;
        chk("done_valid", done_valid, 1);
        chk("done_write", done_write, w);
        chk("done_id", done_id, id);
        chk("done_resp", done_resp, resp);
        chk("cmd_ready_in_done", cmd_ready, 0);
        @(negedge clk);
        chk("done_one_cycle", done_valid, 0);
        chk("cmd_ready_back", cmd_ready, 1);
    endtask

    task automatic do_write(input logic [5:0] a, input logic [7:0] len, input logic [1:0] id,
                            input logic [1:0] br, input logic [1:0] bi,
                            input logic [31:0] vv, input logic [31:0] rv, input int aw_wait);
        int beat = 0;
        int c = 0;
        issue_cmd(1'b1, a, len, id);
        wr_valid = 1;
        wr_data  = beat_data[0];
        wr_strb  = beat_strb[0];
        wready   = 1;
        for (int i = 0; i < aw_wait; i++) begin
            awready = 0;
            #1;
            chk("awvalid_hold", awvalid, 1);
            chk("no_w_before_aw", {wvalid, wr_ready}, 0);
            @(negedge clk);
        end
        awready = 1;
        #1;
        chk("awvalid", awvalid, 1);
        chk("no_w_before_aw", {wvalid, wr_ready}, 0);
        chk("awaddr", awaddr, a);
        chk("awlen", awlen, len);
        chk("awsize", awsize, 3'b010);
        chk("awburst", awburst, 2'b01);
        chk("awid", awid, id);
        @(negedge clk);
        awready = 0;
        while (beat <= int'(len) && c < 2000) begin
            wr_valid = vv[c % 32];
            wready   = rv[c % 32];
            wr_data  = beat_data[beat];
            wr_strb  = beat_strb[beat];
            #1;
            chk("wvalid", wvalid, wr_valid);
            chk("wr_ready", wr_ready, wready);
            if (wr_valid && wready) begin
                chk("wdata", wdata, beat_data[beat]);
                chk("wstrb", wstrb, beat_strb[beat]);
                chk("wlast", wlast, beat == int'(len));
                beat++;
            end
            c++;
            @(negedge clk);
        end
        chk("w_beat_count", beat, int'(len) + 1);
        wr_valid = 0;
        wready   = 0;
        #1;
        chk("bready_wait", bready, 1);
        chk("no_done_before_b", done_valid, 0);
        @(negedge clk);
        bvalid = 1; bresp = br; bid = bi;
        #1;
        chk("bready", bready, 1);
        @(negedge clk);
        bvalid = 0;
        check_done(1'b1, id, (bi != id) ? 2'b10 : br);
    endtask

    task automatic do_read(input logic [5:0] a, input logic [7:0] len, input logic [1:0] id,
                           input logic [31:0] vv, input logic [31:0] rv, input int ar_wait);
        int beat = 0;
        int c = 0;
        issue_cmd(1'b0, a, len, id);
        for (int i = 0; i < ar_wait; i++) begin
            arready = 0;
            #1;
            chk("arvalid_hold", arvalid, 1);
            chk("awvalid_on_read", awvalid, 0);
            @(negedge clk);
        end
        arready = 1;
        #1;
        chk("arvalid", arvalid, 1);
        chk("araddr", araddr, a);
        chk("arlen", arlen, len);
        chk("arsize", arsize, 3'b010);
        chk("arburst", arburst, 2'b01);
        chk("arid", arid, id);
        @(negedge clk);
        arready = 0;
        while (beat <= int'(len) && c < 2000) begin
            rvalid   = vv[c % 32];
            rd_ready = rv[c % 32];
            rdata    = beat_data[beat];
            rresp    = beat_resp[beat];
            rlast    = beat_last[beat];
            #1;
            chk("rd_valid", rd_valid, rvalid);
            chk("rready", rready, rd_ready);
            if (rvalid && rd_ready) begin
                chk("rd_data", rd_data, beat_data[beat]);
                chk("rd_last", rd_last, beat == int'(len));
                beat++;
            end
            c++;
            @(negedge clk);
        end
        chk("r_beat_count", beat, int'(len) + 1);
        rvalid = 0; rd_ready = 0; rlast = 0;
        check_done(1'b0, id, exp_read_resp(int'(len)));
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_valids", {awvalid, wvalid, bready, arvalid, rready, rd_valid, done_valid}, 0);
        chk("rst_payload", {awaddr, awlen, awsize, awburst, araddr, arlen, done_resp}, 0);
        @(negedge clk);
        rst = 0;
        #1;
        chk("idle_cmd_ready", cmd_ready, 1);
        @(negedge clk);

        // Single write, unaligned address, one beat.
        fill_beats(0, 0);
        beat_data[0] = 32'hFFFF_FFFF;
        beat_strb[0] = 4'h1;
        do_write(6'h01, 8'd0, 2'd0, 2'b00, 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);

        // Three-beat write with wready toggling 1-0-1.
        fill_beats(2, 0);
        beat_data[0] = 32'hABAB_ABAB;
        beat_data[1] = 32'hCDCD_CDCD;
        beat_data[2] = 32'hEFEF_EFEF;
        do_write(6'h08, 8'd2, 2'd1, 2'b00, 2'd1, 32'hFFFF_FFFF, 32'h5555_5555, 1);

        // Four-beat read, SLVERR on beat 2, rd_ready stalled for two cycles.
        fill_beats(3, 0);
        beat_resp[2] = 2'b10;
        do_read(6'h00, 8'd3, 2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 0);

        // rlast early on beat 1 (and thus missing on beat 3).
        fill_beats(3, 0);
        beat_last[1] = 1;
        beat_last[3] = 0;
        do_read(6'h10, 8'd3, 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);

        // Wrong BID.
        fill_beats(0, 0);
        do_write(6'h04, 8'd0, 2'd3, 2'b00, 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);

        // Oversized commands: rejected with no bus traffic.
        issue_cmd(1'b1, 6'h00, 8'd16, 2'd3);
        #1;
        chk("reject_no_aw", {awvalid, arvalid, wvalid}, 0);
        check_done(1'b1, 2'd3, 2'b10);
        issue_cmd(1'b0, 6'h00, 8'd255, 2'd1);
        #1;
        chk("reject_no_ar", {awvalid, arvalid, rvalid}, 0);
        check_done(1'b0, 2'd1, 2'b10);

        // Reset during W beat 2 of 4.
        fill_beats(3, 0);
        issue_cmd(1'b1, 6'h20, 8'd3, 2'd2);
        awready = 1;
        @(negedge clk);
        awready = 0; wr_valid = 1; wready = 1; wr_data = beat_data[0];
        @(negedge clk);
        wr_data = beat_data[1];
        rst = 1;
        @(negedge clk);
        rst = 0; wr_valid = 0; wready = 0;
        #1;
        chk("rst_mid_valids", {awvalid, wvalid, bready, arvalid, rready, rd_valid, done_valid}, 0);
        chk("rst_mid_cmd_ready", cmd_ready, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_mid_no_done", done_valid, 0);
        end
        fill_beats(1, 0);
        do_write(6'h24, 8'd1, 2'd2, 2'b01, 2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);

        // Randomized mix.
        for (int t = 0; t < 24; t++) begin
            logic [7:0]  l;
            logic [1:0]  id;
            logic [1:0]  bi;
            logic [5:0]  a;
            logic [31:0] vv, rv;
            l  = 8'($urandom_range(0, 15));
            id = 2'($urandom);
            a  = 6'($urandom_range(0, 15) * 4);
            vv = $urandom | 32'h1111_1111;
            rv = $urandom | 32'h1111_1111;
            fill_beats(int'(l), 1);
            if ($urandom_range(0, 1) == 1) begin
                bi = ($urandom_range(0, 3) == 0) ? ~id : id;
                do_write(a, l, id, 2'($urandom), bi, vv, rv, $urandom_range(0, 2));
            end else begin
                if ($urandom_range(0, 3) == 0) begin
                    int k = $urandom_range(0, int'(l));
                    beat_last[k] = ~beat_last[k];
                end
                do_read(a, l, id, vv, rv, $urandom_range(0, 2));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
